// File: rtl/seg7_scan_rx.sv
// seg7_scan_rx
//   Receiver for a time-multiplexed, active-low 7-segment display bus.
//   DIG/SEG are registered once, each digit's pattern is qualified for
//   STABLE consecutive identical samples, then inverse-decoded to a hex
//   nibble with per-digit validity.
//
// Parameters
//   STABLE  consecutive identical samples needed for a capture (2..255)
//   NDIG    number of multiplexed digits (1..8)
//
// Ports
//   CLK     system clock, rising edge
//   RST     asynchronous reset, active-low
//   DIG     digit select, active-low, one-hot-low selects a digit
//   SEG     segment lines gfedcba, 0 = lit
//   HEXOUT  captured nibbles, digit i in HEXOUT[4i+3:4i]
//   VALID   per-digit: last capture was a legal glyph
//   UPD     one-cycle pulse: legal glyph captured
//   ERR     one-cycle pulse: illegal non-blank pattern captured
//   IDX     digit index of the most recent capture
module seg7_scan_rx #(
  parameter int unsigned STABLE = 4,
  parameter int unsigned NDIG   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NDIG-1:0]   DIG,
  input  logic [6:0]        SEG,
  output logic [4*NDIG-1:0] HEXOUT,
  output logic [NDIG-1:0]   VALID,
  output logic              UPD,
  output logic              ERR,
  output logic [2:0]        IDX
);

  localparam logic [7:0] STABLE_C = 8'(STABLE);

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    HELD
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [7:0]      cnt;
  logic [7:0]      cnt_n;

  logic [NDIG-1:0] s_dig;
  logic [6:0]      s_seg;
  logic [NDIG-1:0] p_dig;
  logic [6:0]      p_seg;

  logic [NDIG-1:0] low;
  logic            onehot;
  logic            changed;
  logic            cap;
  logic [2:0]      cap_idx;
  logic [3:0]      nib;
  logic            legal;
  logic            blank;

  // Inverse glyph decode: {legal, nibble}
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b1000000: r = {1'b1, 4'h0};
      7'b1111001: r = {1'b1, 4'h1};
      7'b0100100: r = {1'b1, 4'h2};
      7'b0110000: r = {1'b1, 4'h3};
      7'b0011001: r = {1'b1, 4'h4};
      7'b0010010: r = {1'b1, 4'h5};
      7'b0000010: r = {1'b1, 4'h6};
      7'b1011000: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0010000: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b0000011: r = {1'b1, 4'hB};
      7'b1000110: r = {1'b1, 4'hC};
      7'b0100001: r = {1'b1, 4'hD};
      7'b0000110: r = {1'b1, 4'hE};
      7'b0001110: r = {1'b1, 4'hF};
      default:    r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  // Sample register plus a copy of the previous sample for the
  // stability compare. Both reset to all ones so the first real sample
  // after reset always counts as a change.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s_dig <= '1;
      s_seg <= '1;
      p_dig <= '1;
      p_seg <= '1;
    end else begin
      s_dig <= DIG;
      s_seg <= SEG;
      p_dig <= s_dig;
      p_seg <= s_seg;
    end
  end

  // Digit-select qualification
  always_comb begin
    low     = ~s_dig;
    onehot  = (low != '0) && ((low & (low - 1'b1)) == '0);
    changed = (s_dig != p_dig) || (s_seg != p_seg);
    cap_idx = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (low[i]) cap_idx = 3'(i);
    end
  end

  always_comb begin
    {legal, nib} = decode(s_seg);
    blank        = (s_seg == 7'b1111111);
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // FSM next-state; the count is of samples equal to the first one of
  // the dwell, so a reload sets it to 1, not 0.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    if (!onehot) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (changed || (state == IDLE)) begin
      state_n = DWELL;
      cnt_n   = 8'd1;
    end else if (state == DWELL) begin
      cnt_n = cnt + 8'd1;
      if (cnt_n >= STABLE_C) begin
        cnt_n   = STABLE_C;
        cap     = 1'b1;
        state_n = HELD;
      end
    end
  end

  // Registered capture outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      HEXOUT <= '0;
      VALID  <= '0;
      UPD    <= 1'b0;
      ERR    <= 1'b0;
      IDX    <= '0;
    end else begin
      UPD <= 1'b0;
      ERR <= 1'b0;
      if (cap) begin
        IDX <= cap_idx;
        UPD <= legal;
        ERR <= !legal && !blank;
        for (int unsigned i = 0; i < NDIG; i++) begin
          if (cap_idx == 3'(i)) begin
            VALID[i] <= legal;
            if (legal) HEXOUT[4*i +: 4] <= nib;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_rx.sv
// tb_seg7_scan_rx
//   Table-driven bench for seg7_scan_rx (STABLE=4, NDIG=4) with
//   hand-written sequences for latency, dwell boundary and reset.
module tb_seg7_scan_rx;

  logic        CLK;
  logic        RST;
  logic [3:0]  DIG;
  logic [6:0]  SEG;
  logic [15:0] HEXOUT;
  logic [3:0]  VALID;
  logic        UPD;
  logic        ERR;
  logic [2:0]  IDX;

  int tests  = 0;
  int fails  = 0;
  int nu     = 0;
  int ne     = 0;
  int excl   = 0;

  seg7_scan_rx #(.STABLE(4), .NDIG(4)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .DIG    (DIG),
    .SEG    (SEG),
    .HEXOUT (HEXOUT),
    .VALID  (VALID),
    .UPD    (UPD),
    .ERR    (ERR),
    .IDX    (IDX)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  dig;
    logic [6:0]  seg;
    int          cyc;
    logic [15:0] hex;
    logic [3:0]  vld;
    int          nupd;
    int          nerr;
    logic [2:0]  idx;
  } vec_t;

  vec_t tv[$];
  logic [6:0] glyph[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      if (UPD) nu++;
      if (ERR) ne++;
      if (UPD && ERR) excl++;
    end
  endtask

  task automatic addv(input logic [3:0] d, input logic [6:0] s, input int c,
                      input logic [15:0] h, input logic [3:0] v,
                      input int u, input int e, input logic [2:0] x);
    vec_t t;
    t.dig = d; t.seg = s; t.cyc = c; t.hex = h; t.vld = v;
    t.nupd = u; t.nerr = e; t.idx = x;
    tv.push_back(t);
  endtask

  initial begin
    glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001;
    glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
    glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010;
    glyph[6]  = 7'b0000010; glyph[7]  = 7'b1011000;
    glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000;
    glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
    glyph[12] = 7'b1000110; glyph[13] = 7'b0100001;
    glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;

    //    dig      seg         cyc hex      vld     u  e  idx
    addv(4'b1110, 7'b0100100, 20, 16'h0002, 4'b0001, 0, 0, 3'd0);
    addv(4'b1101, 7'b1011000,  6, 16'h0072, 4'b0011, 1, 0, 3'd1);
    addv(4'b1011, 7'b0001000,  3, 16'h0072, 4'b0011, 0, 0, 3'd1);
    addv(4'b1011, 7'b0000011,  3, 16'h0072, 4'b0011, 0, 0, 3'd1);
    addv(4'b1011, 7'b0001000,  3, 16'h0072, 4'b0011, 0, 0, 3'd1);
    addv(4'b1011, 7'b0000011,  3, 16'h0072, 4'b0011, 0, 0, 3'd1);
    addv(4'b1011, 7'b0010000,  6, 16'h0972, 4'b0111, 1, 0, 3'd2);
    addv(4'b1011, 7'b0101010,  6, 16'h0972, 4'b0011, 0, 1, 3'd2);
    addv(4'b1011, 7'b1111111,  6, 16'h0972, 4'b0011, 0, 0, 3'd2);
    addv(4'b1011, 7'b0010000,  6, 16'h0972, 4'b0111, 1, 0, 3'd2);
    addv(4'b1011, 7'b1111111,  6, 16'h0972, 4'b0011, 0, 0, 3'd2);
    addv(4'b1100, 7'b0010000, 10, 16'h0972, 4'b0011, 0, 0, 3'd2);
    addv(4'b1111, 7'b0010000, 10, 16'h0972, 4'b0011, 0, 0, 3'd2);
    addv(4'b1110, 7'b0001000,  6, 16'h097A, 4'b0011, 1, 0, 3'd0);
    addv(4'b1101, 7'b0000011,  6, 16'h09BA, 4'b0011, 1, 0, 3'd1);
    addv(4'b1011, 7'b1000110,  6, 16'h0CBA, 4'b0111, 1, 0, 3'd2);
    addv(4'b0111, 7'b0100001,  6, 16'hDCBA, 4'b1111, 1, 0, 3'd3);

    // Reset state
    RST = 1'b1; DIG = '1; SEG = '1;
    #2 RST = 1'b0;
    #1;
    chk("rst_hex", 32'(HEXOUT), 32'h0);
    chk("rst_valid", 32'(VALID), 32'h0);
    chk("rst_pulses", 32'({UPD, ERR}), 32'h0);
    chk("rst_idx", 32'(IDX), 32'h0);
    run(2);
    RST = 1'b1;
    run(1);

    // First capture latency: samples at e1..e4, outputs at e5
    DIG = 4'b1110; SEG = 7'b0100100;
    nu = 0; ne = 0;
    run(4);
    chk("lat_early_upd", 32'(nu), 32'd0);
    run(1);
    chk("lat_upd_e5", 32'(UPD), 32'd1);
    run(1);
    chk("lat_upd_one_cycle", 32'(UPD), 32'd0);
    chk("lat_hex", 32'(HEXOUT), 32'h0002);
    chk("lat_valid", 32'(VALID), 32'h1);
    chk("lat_idx", 32'(IDX), 32'd0);

    for (int i = 0; i < tv.size(); i++) begin
      DIG = tv[i].dig; SEG = tv[i].seg;
      nu = 0; ne = 0;
      run(tv[i].cyc);
      chk($sformatf("v%0d_hex", i), 32'(HEXOUT), 32'(tv[i].hex));
      chk($sformatf("v%0d_valid", i), 32'(VALID), 32'(tv[i].vld));
      chk($sformatf("v%0d_upd", i), 32'(nu), 32'(tv[i].nupd));
      chk($sformatf("v%0d_err", i), 32'(ne), 32'(tv[i].nerr));
      chk($sformatf("v%0d_idx", i), 32'(IDX), 32'(tv[i].idx));
    end

    // Every glyph decoded on digit 0
    for (int k = 0; k < 16; k++) begin
      DIG = 4'b1110; SEG = glyph[k];
      nu = 0; ne = 0;
      run(6);
      chk($sformatf("g%0d_hex", k), 32'(HEXOUT), 32'({12'hDCB, 4'(k)}));
      chk($sformatf("g%0d_upd", k), 32'(nu), 32'd1);
    end
    chk("glyph_valid", 32'(VALID), 32'hF);

    // Dwell of only 3 samples: no capture
    nu = 0; ne = 0;
    DIG = 4'b1101; SEG = glyph[3];
    run(3);
    DIG = 4'b1111;
    run(6);
    chk("short_dwell_upd", 32'(nu), 32'd0);
    chk("short_dwell_hex", 32'(HEXOUT), 32'hDCBF);

    // Dwell of exactly 4 samples: capture
    nu = 0; ne = 0;
    DIG = 4'b1101; SEG = glyph[3];
    run(4);
    DIG = 4'b1111;
    run(3);
    chk("exact_dwell_upd", 32'(nu), 32'd1);
    chk("exact_dwell_hex", 32'(HEXOUT), 32'hDC3F);
    chk("exact_dwell_idx", 32'(IDX), 32'd1);

    // Reset mid-dwell (counter at 3), then a full new dwell is needed
    DIG = 4'b1011; SEG = glyph[5];
    run(4);
    RST = 1'b0;
    #1;
    chk("mid_rst_hex", 32'(HEXOUT), 32'h0);
    chk("mid_rst_valid", 32'(VALID), 32'h0);
    chk("mid_rst_idx", 32'(IDX), 32'd0);
    run(2);
    RST = 1'b1;
    nu = 0; ne = 0;
    run(4);
    chk("post_rst_early", 32'(nu), 32'd0);
    run(1);
    chk("post_rst_upd", 32'(UPD), 32'd1);
    chk("post_rst_hex", 32'(HEXOUT), 32'h0500);
    chk("post_rst_valid", 32'(VALID), 32'h4);
    chk("post_rst_idx", 32'(IDX), 32'd2);
    run(10);
    chk("post_rst_held_upd", 32'(nu), 32'd1);

    chk("upd_err_exclusive", 32'(excl), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_rx.md
# seg7_scan_rx

Receiver for a time-multiplexed, active-low 7-segment display bus. It samples the digit-select and segment lines and qualifies each digit's pattern for stability. It then inverse-decodes the pattern back to a 4-bit hex nibble per digit, with per-digit validity and error flags. It sits on the far end of the hex-to-segment display path, where it is used for display readback, self-check and loopback test of the segment driver chain.

## Interface
- STABLE, 4: consecutive identical samples required before a capture; legal range 2–255.
- NDIG, 4: number of multiplexed digits; legal range 1–8.
- CLK  in  1  single system clock; all logic on rising edge.
- RST  in  1  reset; asynchronous, active-low.
- DIG  in  NDIG  digit select, active-low; exactly one bit low means that digit is being driven.
- SEG  in  7  segment lines, order gfedcba, 0 = lit.
- HEXOUT  out  4*NDIG  captured nibbles; digit i in HEXOUT[4i+3:4i].
- VALID  out  NDIG  VALID[i]=1 when digit i's last capture was a legal glyph.
- UPD  out  1  one-cycle pulse: a legal glyph was captured.
- ERR  out  1  one-cycle pulse: an illegal (non-blank) pattern was captured.
- IDX  out  3  index of the digit for the most recent capture (legal, blank or illegal).

## Operation
- DIG and SEG are registered once at the input (sample register). All qualification uses the sampled values.
- Glyph table, SEG value to nibble:
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1011000
  - 8:0000000, 9:0010000, A:0001000, b:0000011
  - C:1000110, d:0100001, E:0000110, F:0001110
- Blank = 1111111. Any other pattern is illegal.
- FSM states:
  - IDLE: sampled DIG is not exactly one-hot-low (none or several low). Counter is 0; no capture.
  - DWELL: a one-hot DIG is present. The counter increments on each sample equal to the previous sample (DIG and SEG both). Any change reloads the counter to 1 and stays in DWELL, or goes to IDLE if DIG is no longer one-hot. When the counter reaches STABLE, perform the capture and go to HELD.
  - HELD: the capture is done for this dwell. Stay while samples are unchanged; no repeat capture. Any change goes to DWELL (counter=1) or to IDLE.
- Capture for digit i (i = position of the low DIG bit):
  - Legal glyph: HEXOUT[i] = nibble, VALID[i] = 1, UPD pulses, IDX = i.
  - Blank: VALID[i] = 0, HEXOUT[i] holds, no UPD/ERR, IDX = i.
  - Illegal: VALID[i] = 0, HEXOUT[i] holds, ERR pulses, IDX = i.
- Other digits' HEXOUT/VALID are never affected by a capture.
- The counter saturates at STABLE; it cannot wrap while in HELD.

## Timing
- Reset values (asynchronous, immediate on RST=0): HEXOUT=0, VALID=0, UPD=0, ERR=0, IDX=0, FSM=IDLE, counter=0, sample register = all ones (DIG and SEG).
- Latency: the new value is sampled at edges e1..eSTABLE, identical each time. HEXOUT/VALID/IDX/UPD/ERR update at edge e(STABLE+1).
- UPD and ERR are high exactly one cycle and are mutually exclusive.
- Minimum dwell for capture: STABLE cycles of unchanged bus. Shorter dwells produce no output change.
- Reset mid-dwell discards the partial count. After RST release a full STABLE-sample dwell is required, even if the bus is unchanged.
- A change at the same edge the counter would reach STABLE means no capture (the compare uses the new sample).
- Outputs are registered; there are no combinational paths from DIG/SEG to outputs.

## Test plan
- STABLE=4, after reset: DIG=1110, SEG=0100100 held 6 cycles -> one UPD pulse 5 edges after first sample, IDX=0, HEXOUT[3:0]=2, VALID=0001.
- Same input held 20 more cycles -> no further UPD/ERR. Then DIG=1101, SEG=1011000 -> HEXOUT[7:4]=7, VALID=0011.
- DIG=1011, SEG toggles every 3 cycles between 0001000 and 0000011 -> no capture, outputs unchanged.
- DIG=1011, SEG=0101010 held -> ERR pulse, IDX=2, VALID[2]=0, HEXOUT[11:8] unchanged. Then SEG=1111111 held -> no ERR/UPD, VALID[2]=0.
- DIG=1100 or 1111 held 10 cycles -> no capture. Round-robin scan of A,b,C,d on digits 0..3, 6 cycles each -> HEXOUT=16'hDCBA, VALID=1111, four UPD pulses.
- RST low at counter=3 -> all outputs 0 immediately. Release with the bus unchanged -> capture only after 4 new samples.
